insn_split: RTL and testbench
=============================

// Module: insn_split
// PURPOSE
//  Fetch-to-decode stage for the ZipCPU. It accepts one 32-bit word at a time
//  from the single-word prefetch and presents one instruction at a time to
//  decode. A word with bit 31 set holds a compressed pair: two 15-bit halves.
//  Pairs are emitted as two sequential instructions, and the prefetch is held
//  off until the second half is consumed. Words fetched with a bus error pass
//  through as a single illegal instruction.
// PARAMETERS
//  AW   32   instruction address width; matches prefetch ADDRESS_WIDTH
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   reset: synchronous, active-high
//  i_clear          in   1   pipeline flush (branch/interrupt), synchronous
//  i_pf_valid       in   1   prefetch word valid
//  i_pf_insn        in   32  prefetch instruction word
//  i_pf_pc          in   AW  address of i_pf_insn
//  i_pf_illegal     in   1   word fetched with bus error
//  o_pf_stalled_n   out  1   ready to prefetch; word accepted when set with i_pf_valid
//  i_dcd_ready      in   1   decode accepts o_insn this cycle
//  o_valid          out  1   o_insn valid toward decode
//  o_insn           out  32  instruction; compressed half = {1'b1,half[14:0],16'h0}
//  o_pc             out  AW  word address (same for both halves)
//  o_half           out  1   0 = full word or first half, 1 = second half
//  o_illegal        out  1   instruction carries a fetch bus error
// BEHAVIOUR
//  - Reset: state IDLE, word register 0; o_valid=0, o_insn=0, o_pc=0,
//    o_half=0, o_illegal=0.
//  - States: IDLE (empty), SINGLE (full word or illegal out), FIRST (pair,
//    half A out), SECOND (pair, half B out).
//  - Handshake: take = i_pf_valid & o_pf_stalled_n; consume = o_valid & i_dcd_ready.
//  - o_pf_stalled_n = !o_valid | (i_dcd_ready & state!=FIRST), with this
//    exception: in FIRST, it is also 1 when the held second half is HNOP.
//  - HNOP = 15'h7FFF. A second half equal to HNOP is dropped. That pair acts
//    as SINGLE (half A only), and SECOND is skipped.
//  - On take, the next state is chosen from the word:
//    - i_pf_illegal=1: SINGLE, o_illegal=1, o_insn=i_pf_insn (bit 31 ignored).
//    - bit 31=0: SINGLE, o_insn=i_pf_insn.
//    - bit 31=1: FIRST, o_insn={1,i_pf_insn[30:16],16'h0}. Low half latched.
//  - Latency: word taken at edge N is valid on o_valid after edge N (1 clk).
//  - FIRST & consume (B not HNOP): SECOND, o_insn={1,held[14:0],16'h0},
//    o_half=1. o_pc is unchanged and no take occurs.
//  - SINGLE/SECOND/FIRST-with-HNOP & consume: take in the same cycle if
//    i_pf_valid (back-to-back, zero bubble); otherwise go IDLE, o_valid=0.
//  - Not consumed (o_valid & !i_dcd_ready): all outputs hold.
//  - i_clear: next state IDLE, o_valid=0, held half discarded. A word offered
//    in that cycle is NOT taken (o_pf_stalled_n forced 1 so the prefetch
//    discards it). i_rst dominates i_clear.
//  - i_clear in FIRST: the second half is never emitted.
//  - o_insn/o_pc/o_illegal only change on take or FIRST->SECOND.
// CONFIGURATION
//  - Macro OPT_CIS_EN, when defined: pair splitting as above.
//  - When undefined: bit 31 is ignored and every word goes SINGLE. FIRST and
//    SECOND are unreachable, o_half is tied 0, and HNOP logic is removed.
// TESTING
//  1. Reset, offer 32'h0123_4567 @pc 0x100, dcd_ready=1 -> next clk:
//     o_valid=1, o_insn=32'h0123_4567, o_half=0; o_pf_stalled_n stays 1.
//  2. Offer 32'h8001_0002 @0x104 -> o_insn=32'h8001_0000,o_half=0;
//     then 32'h8002_0000,o_half=1; o_pc=0x104 both; stalled_n=0 in FIRST.
//  3. Offer 32'hFFFF_7FFF (B=HNOP) -> only 32'hFFFF_0000 emitted; the next
//     word is accepted in the same cycle as A is consumed.
//  4. Pair held in FIRST with dcd_ready=0 for 3 clks -> outputs hold;
//     assert i_clear -> o_valid=0 next clk, second half never appears.
//  5. Offer 32'h8000_0001 with i_pf_illegal=1 -> one output:
//     o_insn=32'h8000_0001, o_illegal=1, o_half=0.
//  6. Build without OPT_CIS_EN, offer 32'h8001_0002 -> single output
//     32'h8001_0002, o_half=0.

Source files
------------

// File: rtl/insn_split.sv
// insn_split: fetch-to-decode stage; splits compressed instruction pairs into two halves.
// Pair splitting is enabled by the OPT_CIS_EN macro; without it every word is a single instruction.
`default_nettype none

module insn_split #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_pf_valid,
  input  logic [31:0]   i_pf_insn,
  input  logic [AW-1:0] i_pf_pc,
  input  logic          i_pf_illegal,
  output logic          o_pf_stalled_n,
  input  logic          i_dcd_ready,
  output logic          o_valid,
  output logic [31:0]   o_insn,
  output logic [AW-1:0] o_pc,
  output logic          o_half,
  output logic          o_illegal
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    FIRST  = 2'd2,
    SECOND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     insn_q, insn_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            illegal_q, illegal_d;
  logic            take, consume, take_pair, hold_first;

`ifdef OPT_CIS_EN
  localparam logic [14:0] HNOP = 15'h7FFF;
  logic [14:0]     held_q, held_d;
  logic            half_q, half_d;

  // A pair whose second half is HNOP behaves like a single word in FIRST.
  assign hold_first = (state_q == FIRST) && (held_q != HNOP);
  assign take_pair  = !i_pf_illegal && i_pf_insn[31];
  assign o_half     = half_q;
`else
  assign hold_first = 1'b0;
  assign take_pair  = 1'b0;
  assign o_half     = 1'b0;
`endif

  assign o_valid        = (state_q != IDLE);
  assign consume        = o_valid && i_dcd_ready;
  assign o_pf_stalled_n = i_clear || !o_valid || (i_dcd_ready && !hold_first);
  // A flush leaves the ready line high so the prefetch drops its word.
  assign take           = i_pf_valid && o_pf_stalled_n && !i_clear;

  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
`ifdef OPT_CIS_EN
    held_d    = held_q;
    half_d    = half_q;
`endif
    if (i_clear) begin
      state_d = IDLE;
`ifdef OPT_CIS_EN
      held_d  = '0;
`endif
    end else if (consume && hold_first) begin
      state_d = SECOND;
`ifdef OPT_CIS_EN
      insn_d  = {1'b1, held_q, 16'h0000};
      half_d  = 1'b1;
`endif
    end else if (take) begin
      pc_d      = i_pf_pc;
      illegal_d = i_pf_illegal;
`ifdef OPT_CIS_EN
      half_d    = 1'b0;
      held_d    = i_pf_insn[14:0];
`endif
      if (take_pair) begin
        state_d = FIRST;
        insn_d  = {1'b1, i_pf_insn[30:16], 16'h0000};
      end else begin
        state_d = SINGLE;
        insn_d  = i_pf_insn;
      end
    end else if (consume) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      insn_q    <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
`ifdef OPT_CIS_EN
      held_q    <= '0;
      half_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
`ifdef OPT_CIS_EN
      held_q    <= held_d;
      half_q    <= half_d;
`endif
    end
  end

  assign o_insn    = insn_q;
  assign o_pc      = pc_q;
  assign o_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_insn_split.sv
// Directed self-checking bench for insn_split; expectations follow OPT_CIS_EN if defined.
`default_nettype none

module tb_insn_split;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_pf_valid = 1'b0;
  logic [31:0] i_pf_insn = '0;
  logic [31:0] i_pf_pc = '0;
  logic        i_pf_illegal = 1'b0;
  logic        o_pf_stalled_n;
  logic        i_dcd_ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_insn;
  logic [31:0] o_pc;
  logic        o_half;
  logic        o_illegal;

  int n_checks = 0;
  int n_errors = 0;

  insn_split #(.AW(32)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clear        (i_clear),
    .i_pf_valid     (i_pf_valid),
    .i_pf_insn      (i_pf_insn),
    .i_pf_pc        (i_pf_pc),
    .i_pf_illegal   (i_pf_illegal),
    .o_pf_stalled_n (o_pf_stalled_n),
    .i_dcd_ready    (i_dcd_ready),
    .o_valid        (o_valid),
    .o_insn         (o_insn),
    .o_pc           (o_pc),
    .o_half         (o_half),
    .o_illegal      (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] insn, input logic [31:0] pc, input logic ill);
    i_pf_valid   = 1'b1;
    i_pf_insn    = insn;
    i_pf_pc      = pc;
    i_pf_illegal = ill;
  endtask

  task automatic idle_pf();
    i_pf_valid   = 1'b0;
    i_pf_illegal = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_insn", o_insn, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_half", {31'd0, o_half}, 32'd0);
    check("rst_illegal", {31'd0, o_illegal}, 32'd0);

    // Single full word, one-cycle latency
    i_dcd_ready = 1'b1;
    offer(32'h0123_4567, 32'h100, 1'b0);
    #1 check("t1_stn_idle", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    idle_pf();
    #1;
    check("t1_valid", {31'd0, o_valid}, 32'd1);
    check("t1_insn", o_insn, 32'h0123_4567);
    check("t1_pc", o_pc, 32'h100);
    check("t1_half", {31'd0, o_half}, 32'd0);
    check("t1_stn", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    check("t1_drain", {31'd0, o_valid}, 32'd0);

    // Back-to-back singles, then stall and flush
    offer(32'h1111_1111, 32'h200, 1'b0);
    tick();
    offer(32'h2222_2222, 32'h204, 1'b0);
    #1 check("b2b_stn", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    check("b2b_insn", o_insn, 32'h2222_2222);
    check("b2b_pc", o_pc, 32'h204);
    i_dcd_ready = 1'b0;
    offer(32'h3333_3333, 32'h208, 1'b0);
    #1 check("stall_stn", {31'd0, o_pf_stalled_n}, 32'd0);
    tick();
    tick();
    tick();
    check("stall_valid", {31'd0, o_valid}, 32'd1);
    check("stall_insn", o_insn, 32'h2222_2222);
    i_clear = 1'b1;
    #1 check("clr_stn", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    i_clear = 1'b0;
    idle_pf();
    i_dcd_ready = 1'b1;
    #1;
    check("clr_valid", {31'd0, o_valid}, 32'd0);
    check("clr_insn_hold", o_insn, 32'h2222_2222);
    tick();
    check("clr_notaken", {31'd0, o_valid}, 32'd0);

    // Bus-error word passes through as one illegal instruction
    offer(32'h8000_0001, 32'h300, 1'b1);
    tick();
    idle_pf();
    #1;
    check("ill_insn", o_insn, 32'h8000_0001);
    check("ill_flag", {31'd0, o_illegal}, 32'd1);
    check("ill_half", {31'd0, o_half}, 32'd0);
    check("ill_valid", {31'd0, o_valid}, 32'd1);
    tick();
    check("ill_drain", {31'd0, o_valid}, 32'd0);

`ifdef OPT_CIS_EN
    // Compressed pair: two halves, prefetch held off during half A
    offer(32'h8001_0002, 32'h104, 1'b0);
    tick();
    offer(32'h0000_0AAA, 32'h108, 1'b0);
    #1;
    check("pa_insn", o_insn, 32'h8001_0000);
    check("pa_half", {31'd0, o_half}, 32'd0);
    check("pa_pc", o_pc, 32'h104);
    check("pa_illegal", {31'd0, o_illegal}, 32'd0);
    check("pa_stn", {31'd0, o_pf_stalled_n}, 32'd0);
    tick();
    check("pb_insn", o_insn, 32'h8002_0000);
    check("pb_half", {31'd0, o_half}, 32'd1);
    check("pb_pc", o_pc, 32'h104);
    check("pb_stn", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    check("pn_insn", o_insn, 32'h0000_0AAA);
    check("pn_pc", o_pc, 32'h108);
    check("pn_half", {31'd0, o_half}, 32'd0);
    // Pair with HNOP second half
    offer(32'hFFFF_7FFF, 32'h10C, 1'b0);
    tick();
    offer(32'h0000_0BBB, 32'h110, 1'b0);
    #1;
    check("hnop_insn", o_insn, 32'hFFFF_0000);
    check("hnop_half", {31'd0, o_half}, 32'd0);
    check("hnop_stn", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    idle_pf();
    #1;
    check("hnop_next", o_insn, 32'h0000_0BBB);
    check("hnop_next_pc", o_pc, 32'h110);
    tick();
    check("hnop_drain", {31'd0, o_valid}, 32'd0);
    // Pair stalled in FIRST then flushed
    i_dcd_ready = 1'b0;
    offer(32'h8005_0006, 32'h120, 1'b0);
    tick();
    idle_pf();
    tick();
    tick();
    tick();
    check("fs_valid", {31'd0, o_valid}, 32'd1);
    check("fs_insn", o_insn, 32'h8005_0000);
    check("fs_stn", {31'd0, o_pf_stalled_n}, 32'd0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_dcd_ready = 1'b1;
    #1;
    check("fc_valid", {31'd0, o_valid}, 32'd0);
    tick();
    check("fc_noB", {31'd0, o_valid}, 32'd0);
    check("fc_insn", o_insn, 32'h8005_0000);
`else
    // Bit 31 ignored: words go out whole
    offer(32'h8001_0002, 32'h104, 1'b0);
    tick();
    offer(32'hFFFF_7FFF, 32'h108, 1'b0);
    #1;
    check("nc_insn", o_insn, 32'h8001_0002);
    check("nc_half", {31'd0, o_half}, 32'd0);
    check("nc_pc", o_pc, 32'h104);
    check("nc_stn", {31'd0, o_pf_stalled_n}, 32'd1);
    tick();
    idle_pf();
    #1;
    check("nc2_insn", o_insn, 32'hFFFF_7FFF);
    check("nc2_half", {31'd0, o_half}, 32'd0);
    tick();
    check("nc_drain", {31'd0, o_valid}, 32'd0);
`endif

    // Reset wins over a concurrent flush and clears outputs
    offer(32'h4444_4444, 32'h400, 1'b1);
    tick();
    idle_pf();
    i_rst = 1'b1;
    i_clear = 1'b1;
    tick();
    i_rst = 1'b0;
    i_clear = 1'b0;
    #1;
    check("rst2_valid", {31'd0, o_valid}, 32'd0);
    check("rst2_insn", o_insn, 32'd0);
    check("rst2_illegal", {31'd0, o_illegal}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
